// File: rtl/data_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_responder_pkg
//   Shared constants and helpers for the data-memory responder.
//   - MMIO_PAGE_DEFAULT : addr[31:16] value that selects the register page
//   - MMIO_* offsets    : register offsets within the page (addr[7:0])
//   - mmio_reg_e        : decoded register identifier
//   - lane_merge()      : byte-lane write merge (old word, new word, select)
//   - mmio_decode()     : offset -> register identifier
// -----------------------------------------------------------------------------
package data_ram_responder_pkg;

    localparam logic [15:0] MMIO_PAGE_DEFAULT = 16'hBFAF;

    localparam logic [7:0] MMIO_TIMER_LO = 8'h00;
    localparam logic [7:0] MMIO_TIMER_HI = 8'h04;
    localparam logic [7:0] MMIO_SCRATCH  = 8'h08;
    localparam logic [7:0] MMIO_LED      = 8'h0C;
    localparam logic [7:0] MMIO_HALT     = 8'h10;
    localparam logic [7:0] MMIO_RDCNT    = 8'h14;
    localparam logic [7:0] MMIO_WRCNT    = 8'h18;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TIMER_LO,
        REG_TIMER_HI,
        REG_SCRATCH,
        REG_LED,
        REG_HALT,
        REG_RDCNT,
        REG_WRCNT
    } mmio_reg_e;

    // Lanes with select=1 take the new byte, the rest keep the old byte.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Counter offsets always decode here; the register block decides
    // whether they are actually backed by storage.
    function automatic mmio_reg_e mmio_decode(input logic [7:0] offset);
        case (offset)
            MMIO_TIMER_LO: return REG_TIMER_LO;
            MMIO_TIMER_HI: return REG_TIMER_HI;
            MMIO_SCRATCH:  return REG_SCRATCH;
            MMIO_LED:      return REG_LED;
            MMIO_HALT:     return REG_HALT;
            MMIO_RDCNT:    return REG_RDCNT;
            MMIO_WRCNT:    return REG_WRCNT;
            default:       return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// -----------------------------------------------------------------------------
// data_ram_responder_if
//   CPU data-memory port bundle. The core drives the request side, the
//   responder returns combinational load data.
//   ram_en_i        access valid this cycle
//   ram_write_en_i  1 = store, 0 = load
//   ram_addr_i      byte address (bits [1:0] ignored)
//   ram_data_i      store data
//   ram_select_i    byte-lane select for stores
//   ram_data_o      load data (combinational)
//   Modports: master (core side), slave (responder side).
// -----------------------------------------------------------------------------
interface data_ram_responder_if;
    import data_ram_responder_pkg::*;

    logic        ram_en_i;
    logic        ram_write_en_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [3:0]  ram_select_i;
    logic [31:0] ram_data_o;

    modport master (
        output ram_en_i,
        output ram_write_en_i,
        output ram_addr_i,
        output ram_data_i,
        output ram_select_i,
        input  ram_data_o
    );

    modport slave (
        input  ram_en_i,
        input  ram_write_en_i,
        input  ram_addr_i,
        input  ram_data_i,
        input  ram_select_i,
        output ram_data_o
    );

endinterface

// File: rtl/data_ram_responder_mmio.sv
// -----------------------------------------------------------------------------
// data_ram_mmio
//   Memory-mapped register page: 64-bit free-running timer with high-word
//   snapshot, scratch register, LED register, sticky halt flag and, when the
//   DATA_RAM_STAT_EN macro is defined, saturating RAM load/store counters.
//   clk, rst   clock, synchronous active-high reset
//   i_rd_en    load to the register page this cycle
//   i_wr_en    store to the register page this cycle
//   i_offset   register offset (addr[7:0])
//   i_wdata    store data
//   i_sel      store byte lanes
//   i_ram_rd   RAM load this cycle (counter strobe)
//   i_ram_wr   RAM store this cycle (counter strobe)
//   o_rdata    register read data for the selected offset
//   o_led      LED register
//   o_halt     sticky halt flag
// -----------------------------------------------------------------------------
module data_ram_mmio
    import data_ram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [7:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_sel,
    input  logic        i_ram_rd,
    input  logic        i_ram_wr,
    output logic [31:0] o_rdata,
    output logic [15:0] o_led,
    output logic        o_halt
);

    mmio_reg_e   w_reg;
    logic [63:0] r_timer;
    logic [31:0] r_hi_snap;
    logic [31:0] r_scratch;
    logic [15:0] r_led;
    logic        r_halt;
    logic [31:0] w_led_next;
    logic        w_unused_led;

    assign w_reg = mmio_decode(i_offset);

    // LED is 16 bits wide; merge against a zero-extended copy and keep the
    // low half so upper-lane writes simply vanish.
    assign w_led_next   = lane_merge({16'h0000, r_led}, i_wdata, i_sel);
    assign w_unused_led = ^w_led_next[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_hi_snap <= '0;
            r_scratch <= '0;
            r_led     <= '0;
            r_halt    <= 1'b0;
        end else begin
            r_timer <= r_timer + 64'd1;

            // Snapshot the high word alongside a TIMER_LO load so a
            // following TIMER_HI load is coherent with the low word.
            if (i_rd_en && (w_reg == REG_TIMER_LO)) begin
                r_hi_snap <= r_timer[63:32];
            end

            if (i_wr_en) begin
                case (w_reg)
                    REG_SCRATCH: r_scratch <= lane_merge(r_scratch, i_wdata, i_sel);
                    REG_LED:     r_led     <= w_led_next[15:0];
                    REG_HALT: begin
                        if (|i_sel) begin
                            r_halt <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DATA_RAM_STAT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (i_ram_rd && (r_rd_cnt != 32'hFFFF_FFFF)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (i_ram_wr && (|i_sel) && (r_wr_cnt != 32'hFFFF_FFFF)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end
`else
    logic w_unused_stat;
    assign w_unused_stat = i_ram_rd ^ i_ram_wr;
`endif

    always_comb begin
        o_rdata = '0;
        case (w_reg)
            REG_TIMER_LO: o_rdata = r_timer[31:0];
            REG_TIMER_HI: o_rdata = r_hi_snap;
            REG_SCRATCH:  o_rdata = r_scratch;
            REG_LED:      o_rdata = {16'h0000, r_led};
`ifdef DATA_RAM_STAT_EN
            REG_RDCNT:    o_rdata = r_rd_cnt;
            REG_WRCNT:    o_rdata = r_wr_cnt;
`endif
            default:      o_rdata = '0;
        endcase
    end

    assign o_led  = r_led;
    assign o_halt = r_halt;

endmodule

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//   Responder end of the CPU data-memory port. Holds a word-organised RAM
//   (2^ADDR_WIDTH x 32) and a register page selected by addr[31:16]==MMIO_PAGE.
//   Loads return data combinationally in the same cycle; stores commit at the
//   clock edge with byte-lane selects. Optional access counters are built when
//   DATA_RAM_STAT_EN is defined.
//   clk     clock
//   rst     synchronous active-high reset
//   bus     data-memory port (slave modport)
//   led_o   LED register
//   halt_o  sticky halt flag
// -----------------------------------------------------------------------------
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [15:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  bus,
    output logic [15:0]          led_o,
    output logic                 halt_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_mmio_hit;
    logic                  w_load;
    logic                  w_store;
    logic                  w_ram_rd;
    logic                  w_ram_wr;
    logic                  w_mmio_rd;
    logic                  w_mmio_wr;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_mmio_rdata;
    logic [31:0]           w_rdata;
    logic                  w_unused_addr;

    // Address bits above the RAM index alias onto the same words.
    assign w_word_idx    = bus.ram_addr_i[ADDR_WIDTH+1:2];
    assign w_mmio_hit    = (bus.ram_addr_i[31:16] == MMIO_PAGE);
    assign w_unused_addr = ^bus.ram_addr_i;

    assign w_load    = bus.ram_en_i & ~bus.ram_write_en_i;
    assign w_store   = bus.ram_en_i &  bus.ram_write_en_i;
    assign w_ram_rd  = w_load  & ~w_mmio_hit;
    assign w_ram_wr  = w_store & ~w_mmio_hit;
    assign w_mmio_rd = w_load  &  w_mmio_hit;
    assign w_mmio_wr = w_store &  w_mmio_hit;

    // RAM contents are intentionally not reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_wr) begin
            r_mem[w_word_idx] <= lane_merge(r_mem[w_word_idx], bus.ram_data_i, bus.ram_select_i);
        end
    end

    assign w_ram_rdata = r_mem[w_word_idx];

    data_ram_mmio u_mmio (
        .clk      (clk),
        .rst      (rst),
        .i_rd_en  (w_mmio_rd),
        .i_wr_en  (w_mmio_wr),
        .i_offset (bus.ram_addr_i[7:0]),
        .i_wdata  (bus.ram_data_i),
        .i_sel    (bus.ram_select_i),
        .i_ram_rd (w_ram_rd),
        .i_ram_wr (w_ram_wr),
        .o_rdata  (w_mmio_rdata),
        .o_led    (led_o),
        .o_halt   (halt_o)
    );

    // Load data is forced to zero outside a valid load so the mem stage
    // never sees stale RAM contents during reset, idle or store cycles.
    always_comb begin
        w_rdata = '0;
        if (!rst && w_load) begin
            w_rdata = w_mmio_hit ? w_mmio_rdata : w_ram_rdata;
        end
    end

    assign bus.ram_data_o = w_rdata;

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led;
    logic        halt;

    always #5 clk = ~clk;

    data_ram_responder_if bus_if ();

    data_ram_responder dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .led_o  (led),
        .halt_o (halt)
    );

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic en, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel,
                                input logic [31:0] exp_rd, input logic [15:0] exp_led,
                                input logic exp_halt);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.exp_rd = exp_rd; v.exp_led = exp_led; v.exp_halt = exp_halt;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
        bus_if.ram_en_i       = en;
        bus_if.ram_write_en_i = we;
        bus_if.ram_addr_i     = addr;
        bus_if.ram_data_i     = data;
        bus_if.ram_select_i   = sel;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    logic [31:0] exp_rdcnt;
    logic [31:0] exp_wrcnt;

    initial begin
`ifdef DATA_RAM_STAT_EN
        exp_rdcnt = 32'd3;
        exp_wrcnt = 32'd1;
`else
        exp_rdcnt = 32'd0;
        exp_wrcnt = 32'd0;
`endif
        //            en   we   addr           wdata          sel   exp_rd         led       halt
        vecs.push_back(mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0100, 32'h0,         4'hF, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0100, 32'h1122_3344, 4'h5, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDE22_BE44, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDE22_BE44, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 32'h0001_0100, 32'h0,         4'h0, 32'hDE22_BE44, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 32'h0000_000C, 32'h1357_9BDF, 4'hF, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_000C, 32'hABCD_1234, 4'hF, 32'h0000_0000, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_000C, 32'h0,         4'h0, 32'h0000_1234, 16'h1234, 0));
        vecs.push_back(mk(1, 0, 32'h0000_000C, 32'h0,         4'h0, 32'h1357_9BDF, 16'h1234, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_000C, 32'h0000_FF00, 4'h2, 32'h0000_0000, 16'h1234, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_000C, 32'h0,         4'h0, 32'h0000_FF34, 16'hFF34, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_0008, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0008, 32'h0,         4'h0, 32'hCAFE_F00D, 16'hFF34, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_0008, 32'h0000_0077, 4'h1, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0008, 32'h0,         4'h0, 32'hCAFE_F077, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0040, 32'h0,         4'h0, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_0004, 32'h1234_5678, 4'hF, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0004, 32'h0,         4'h0, 32'h0000_0001, 16'hFF34, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0010, 32'h0,         4'h0, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 1, 32'hBFAF_0010, 32'h0000_0001, 4'h1, 32'h0000_0000, 16'hFF34, 0));
        vecs.push_back(mk(1, 0, 32'hBFAF_0010, 32'h0,         4'h0, 32'h0000_0000, 16'hFF34, 1));
        vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDE22_BE44, 16'hFF34, 1));
        vecs.push_back(mk(1, 1, 32'hBFAF_0040, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 16'hFF34, 1));
        vecs.push_back(mk(1, 0, 32'hBFAF_0040, 32'h0,         4'h0, 32'h0000_0000, 16'hFF34, 1));
        vecs.push_back(mk(0, 1, 32'h0000_0100, 32'h0,         4'hF, 32'h0000_0000, 16'hFF34, 1));

        // Reset phase: a load request must still return 0.
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        drive(1, 0, 32'hBFAF_0000, 32'h0, 4'h0);
        #1;
        check32("rst_rdata", bus_if.ram_data_o, 32'h0);
        check32("rst_led",   {16'h0, led},      32'h0);
        check32("rst_halt",  {31'h0, halt},     32'h0);

        // Cycle 0 after reset release: hi_snap reads its reset value.
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'hBFAF_0004, 32'h0, 4'h0);
        #1;
        check32("timer_hi_reset", bus_if.ram_data_o, 32'h0);
        idle();
        repeat (10) @(negedge clk);
        drive(1, 0, 32'hBFAF_0000, 32'h0, 4'h0);
        #1;
        check32("timer_lo_cycle10", bus_if.ram_data_o, 32'h0000_000A);

        // Low-word wrap: snapshot must hold the pre-increment high word.
        @(negedge clk);
        force dut.u_mmio.r_timer = 64'h0000_0000_FFFF_FFFF;
        drive(1, 0, 32'hBFAF_0000, 32'h0, 4'h0);
        #1;
        check32("timer_lo_forced", bus_if.ram_data_o, 32'hFFFF_FFFF);
        #1;
        release dut.u_mmio.r_timer;
        idle();
        repeat (5) @(negedge clk);
        drive(1, 0, 32'hBFAF_0004, 32'h0, 4'h0);
        #1;
        check32("timer_hi_snap", bus_if.ram_data_o, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'hBFAF_0000, 32'h0, 4'h0);
        #1;
        check32("timer_lo_after_wrap", bus_if.ram_data_o, 32'h0000_0005);
        @(negedge clk);
        drive(1, 0, 32'hBFAF_0004, 32'h0, 4'h0);
        #1;
        check32("timer_hi_relatched", bus_if.ram_data_o, 32'h0000_0001);

        // Table-driven RAM / MMIO vectors, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
            #1;
            check32($sformatf("vec%0d_rdata", i), bus_if.ram_data_o, vecs[i].exp_rd);
            check32($sformatf("vec%0d_led", i),   {16'h0, led},      {16'h0, vecs[i].exp_led});
            check32($sformatf("vec%0d_halt", i),  {31'h0, halt},     {31'h0, vecs[i].exp_halt});
        end

        // Reset landing on a store: the store is dropped, registers clear.
        @(negedge clk);
        drive(1, 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 32'h0000_0200, 32'h0000_0055, 4'hF);
        #1;
        check32("rstwr_halt_before", {31'h0, halt}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'h0000_0200, 32'h0, 4'h0);
        #1;
        check32("rstwr_ram_kept", bus_if.ram_data_o, 32'hA5A5_A5A5);
        check32("rstwr_led",      {16'h0, led},      32'h0);
        check32("rstwr_halt",     {31'h0, halt},     32'h0);
        @(negedge clk);
        drive(1, 0, 32'hBFAF_0008, 32'h0, 4'h0);
        #1;
        check32("rstwr_scratch", bus_if.ram_data_o, 32'h0);

        // Access counters from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0000_0100, 32'h0, 4'h0);
            #1;
            check32($sformatf("stat_load%0d", i), bus_if.ram_data_o, 32'hDE22_BE44);
            @(negedge clk);
        end
        drive(1, 1, 32'h0000_0104, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        drive(1, 1, 32'h0000_0108, 32'h0BAD_F00D, 4'h0);
        @(negedge clk);
        drive(1, 0, 32'hBFAF_0014, 32'h0, 4'h0);
        #1;
        check32("stat_rdcnt", bus_if.ram_data_o, exp_rdcnt);
        @(negedge clk);
        drive(1, 0, 32'hBFAF_0018, 32'h0, 4'h0);
        #1;
        check32("stat_wrcnt", bus_if.ram_data_o, exp_wrcnt);
        @(negedge clk);
        drive(1, 0, 32'h0000_0104, 32'h0, 4'h0);
        #1;
        check32("stat_store_data", bus_if.ram_data_o, 32'h0BAD_F00D);

        idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
